// File: rtl/ok8_seqctl_if.sv
// rtl/ok8_seqctl_if.sv - OK-8 sequencer bus: loader, run/step controls and CPU fetch port
interface ok8_seqctl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              run;
    logic              step;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;
    logic [ADDR_W-1:0] cpu_pc;
    logic [DATA_W-1:0] cpu_op1;
    logic [DATA_W-1:0] cpu_op2;
    logic              cpu_step;
    logic              busy;
    logic [2:0]        state;

    modport slave (
        input  run, step, ld_req, ld_addr, ld_data, cpu_pc,
        output ld_ack, cpu_op1, cpu_op2, cpu_step, busy, state
    );

    modport master (
        output run, step, ld_req, ld_addr, ld_data, cpu_pc,
        input  ld_ack, cpu_op1, cpu_op2, cpu_step, busy, state
    );
endinterface

// File: rtl/ok8_seqctl.sv
// rtl/ok8_seqctl.sv - OK-8 sequencer and single-port program-memory arbiter
module ok8_seqctl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int STEP_CYCLES = 1048576
) (
    input  logic          clk,
    input  logic          reset,
    ok8_seqctl_if.slave   bus
);
    localparam int TMR_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_LOAD = 3'd1,
        S_F1   = 3'd2,
        S_F2   = 3'd3,
        S_EXEC = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_start;
    logic              w_wrap;
    logic              w_step_rise;
    logic [TMR_W-1:0]  r_timer;
    logic              r_tick_pend;
    logic              r_step_q;
    logic              r_step_pend;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign w_wrap      = bus.run && (r_timer == TMR_LAST);
    assign w_step_rise = bus.step && !r_step_q;
    assign w_pc_next   = r_pc + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_next;
        end
    end

    // Loader wins over pending fetches; a fetch, once started, always runs to EXEC.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            S_HALT: begin
                if (bus.ld_req) begin
                    w_next = S_LOAD;
                end else if (r_tick_pend || r_step_pend) begin
                    w_start = 1'b1;
                    w_next  = S_F1;
                end
            end
            S_LOAD:  w_next = S_HALT;
            S_F1:    w_next = S_F2;
            S_F2:    w_next = S_EXEC;
            S_EXEC:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer     <= '0;
            r_tick_pend <= 1'b0;
            r_step_q    <= 1'b0;
            r_step_pend <= 1'b0;
            r_pc        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
        end else begin
            r_step_q <= bus.step;
            if (!bus.run) begin
                r_timer     <= '0;
                r_tick_pend <= 1'b0;
            end else begin
                r_timer <= w_wrap ? '0 : r_timer + TMR_W'(1);
                if (w_start) begin
                    r_tick_pend <= 1'b0;
                end else if (w_wrap) begin
                    r_tick_pend <= 1'b1;
                end
            end
            if (w_start) begin
                r_step_pend <= 1'b0;
                r_pc        <= bus.cpu_pc;
            end else if (w_step_rise) begin
                r_step_pend <= 1'b1;
            end
            if (r_state == S_F1) begin
                r_op1 <= r_mem[r_pc];
            end
            if (r_state == S_F2) begin
                r_op2 <= r_mem[w_pc_next];
            end
        end
    end

    // Program memory is deliberately unreset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && !reset) begin
            r_mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign bus.ld_ack   = (r_state == S_LOAD);
    assign bus.cpu_step = (r_state == S_EXEC);
    assign bus.busy     = (r_state != S_HALT);
    assign bus.state    = r_state;
    assign bus.cpu_op1  = r_op1;
    assign bus.cpu_op2  = r_op2;
endmodule
